// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge feeders: operand width and
// the feeder state encoding.
package systolic_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. It exposes the head entry and the
// entry behind it so the consumer can preload its output register on a pop.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign push_s        = wr_en && !full;
    assign pop_s         = rd_en && !empty;
    assign rd_ptr_next_s = rd_ptr_r + PTR_W'(1);

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign next_data = mem_r[rd_ptr_next_s];

    // Storage array; contents are only read where the count marks them valid.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_next_s;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// Buffers one operand stream from the host and presents it to a systolic array
// edge with registered data/waiting/finished outputs, beat count and done pulse.
module operand_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_waiting,
    output logic                  out_finished,
    input  logic                  out_ready,
    output logic [LEN_WIDTH-1:0]  beat_count,
    output logic                  stream_done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    feeder_state_e         state_r;
    feeder_state_e         state_n_s;
    logic                  ready_en_r;
    logic [DATA_WIDTH:0]   head_s;
    logic [DATA_WIDTH:0]   next_s;
    logic [CNT_W-1:0]      count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  cand_valid_s;
    logic [DATA_WIDTH:0]   cand_entry_s;
    logic [DATA_WIDTH-1:0] data_n_s;
    logic                  waiting_n_s;
    logic                  finished_n_s;
    logic [LEN_WIDTH-1:0]  beat_n_s;
    logic                  done_n_s;

    // The presented beat stays in the FIFO until the array takes it, so the
    // output register never adds capacity beyond DEPTH.
    assign wr_ready = ready_en_r && !full_s;
    assign push_s   = wr_valid && wr_ready;
    assign pop_s    = out_waiting && out_ready;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (push_s),
        .wr_data   ({wr_last, wr_data}),
        .rd_en     (pop_s),
        .head_data (head_s),
        .next_data (next_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Head entry as it will stand after this edge's pop; same-edge writes wait a cycle.
    always_comb begin
        cand_valid_s = 1'b0;
        cand_entry_s = head_s;
        if (pop_s) begin
            cand_valid_s = (count_s >= CNT_W'(2));
            cand_entry_s = next_s;
        end else begin
            cand_valid_s = !empty_s;
            cand_entry_s = head_s;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n_s    = state_r;
        data_n_s     = out_data;
        waiting_n_s  = 1'b0;
        finished_n_s = 1'b0;
        beat_n_s     = beat_count;
        done_n_s     = 1'b0;

        if (pop_s && (beat_count != {LEN_WIDTH{1'b1}})) begin
            beat_n_s = beat_count + LEN_WIDTH'(1);
        end else begin
            beat_n_s = beat_count;
        end

        case (state_r)
            IDLE: begin
                if (cand_valid_s) begin
                    state_n_s    = STREAM;
                    waiting_n_s  = 1'b1;
                    data_n_s     = cand_entry_s[DATA_WIDTH-1:0];
                    finished_n_s = cand_entry_s[DATA_WIDTH];
                end else begin
                    state_n_s = IDLE;
                end
            end
            STREAM: begin
                if (pop_s && out_finished) begin
                    state_n_s    = DONE;
                    finished_n_s = 1'b1;
                    done_n_s     = 1'b1;
                end else if (cand_valid_s) begin
                    waiting_n_s  = 1'b1;
                    data_n_s     = cand_entry_s[DATA_WIDTH-1:0];
                    finished_n_s = cand_entry_s[DATA_WIDTH];
                end else begin
                    state_n_s = STREAM;
                end
            end
            DONE: begin
                beat_n_s = LEN_WIDTH'(0);
                if (cand_valid_s) begin
                    state_n_s    = STREAM;
                    waiting_n_s  = 1'b1;
                    data_n_s     = cand_entry_s[DATA_WIDTH-1:0];
                    finished_n_s = cand_entry_s[DATA_WIDTH];
                end else begin
                    state_n_s = IDLE;
                end
            end
            default: begin
                state_n_s = IDLE;
                beat_n_s  = LEN_WIDTH'(0);
            end
        endcase
    end

    // State and output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ready_en_r   <= 1'b0;
            out_data     <= DATA_WIDTH'(0);
            out_waiting  <= 1'b0;
            out_finished <= 1'b0;
            beat_count   <= LEN_WIDTH'(0);
            stream_done  <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            ready_en_r   <= 1'b1;
            out_data     <= data_n_s;
            out_waiting  <= waiting_n_s;
            out_finished <= finished_n_s;
            beat_count   <= beat_n_s;
            stream_done  <= done_n_s;
        end
    end

endmodule
